// File: rtl/aes_pkg.sv
// Shared types and constants for the AES decryption front end.
package aes_pkg;

  localparam int BLK_W  = 128;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {LOAD, RUN, CAPTURE, OUT} state_t;

  function automatic int rounds_for_nk(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_dec_feeder_if.sv
// Valid/ready stream bundle, used for the 32-bit word input and 128-bit block output.
interface aes_dec_feeder_if #(parameter int W = 32) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/aes_dec_feeder.sv
// Collects ciphertext words into a block, runs the iterative AES decryption core
// for exactly CORE_LAT enabled cycles, then offers the plaintext with backpressure.
module aes_dec_feeder
  import aes_pkg::*;
#(
  parameter int NK       = 4,
  parameter int NR       = 10,
  parameter int CORE_LAT = NR + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NK*32-1:0]    key_in,
  input  logic                key_load,
  aes_dec_feeder_if.slave     s,
  aes_dec_feeder_if.master    m,
  output logic [NK*32-1:0]    dec_key,
  output logic [BLK_W-1:0]    dec_state,
  output logic                dec_enable,
  input  logic [BLK_W-1:0]    dec_result,
  output logic                busy,
  output logic [15:0]         blk_count
);

  if (NR != rounds_for_nk(NK)) begin : g_bad_nr
    $error("aes_dec_feeder: NR must equal NK+6");
  end

  localparam int             RW       = $clog2(CORE_LAT + 1);
  localparam logic [RW-1:0]  RND_LOAD = RW'(CORE_LAT - 1);

  state_t              r_state;
  logic [1:0]          r_word_cnt;
  logic [RW-1:0]       r_rnd_cnt;
  logic [NK*32-1:0]    r_key;
  logic [BLK_W-1:0]    r_blk;
  logic                r_enable;
  logic [BLK_W-1:0]    r_m_data;
  logic                r_m_valid;
  logic [15:0]         r_blk_count;
  logic                w_s_ready;
  logic                w_busy;

  // s_ready is held low while reset is asserted so no beat is claimed before release.
  always_comb begin
    w_s_ready = rst_n && (r_state == LOAD);
    w_busy    = (r_state != LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_word_cnt  <= '0;
      r_rnd_cnt   <= '0;
      r_key       <= '0;
      r_blk       <= '0;
      r_enable    <= 1'b0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_blk_count <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          // Key may only change between blocks, before the first word lands.
          if (key_load && (r_word_cnt == 2'd0)) r_key <= key_in;
          if (s.valid && w_s_ready) begin
            r_blk      <= {r_blk[BLK_W-WORD_W-1:0], s.data};
            r_word_cnt <= r_word_cnt + 2'd1;
            if (r_word_cnt == 2'd3) begin
              r_state   <= RUN;
              r_enable  <= 1'b1;
              r_rnd_cnt <= RND_LOAD;
            end
          end
        end
        RUN: begin
          if (r_rnd_cnt == '0) begin
            r_enable <= 1'b0;
            r_state  <= CAPTURE;
          end else begin
            r_rnd_cnt <= r_rnd_cnt - RW'(1);
          end
        end
        CAPTURE: begin
          r_m_data    <= dec_result;
          r_m_valid   <= 1'b1;
          r_blk_count <= r_blk_count + 16'd1;
          r_state     <= OUT;
        end
        OUT: begin
          if (m.ready) begin
            r_m_valid <= 1'b0;
            r_state   <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign s.ready    = w_s_ready;
  assign busy       = w_busy;
  assign m.valid    = r_m_valid;
  assign m.data     = r_m_data;
  assign dec_key    = r_key;
  assign dec_state  = r_blk;
  assign dec_enable = r_enable;
  assign blk_count  = r_blk_count;

endmodule

// File: tb/tb_aes_dec_feeder.sv
// Directed bench for aes_dec_feeder: AES-128 and AES-256 instances with a behavioural core stand-in.
module tb_aes_dec_feeder;
  import aes_pkg::*;

  localparam logic [127:0] KA   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CA   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PA   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] GARB = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic         clk;
  logic         rst_n;
  logic [127:0] key128, dk128, ds128, res128;
  logic [255:0] key256, dk256;
  logic [127:0] ds256, res256;
  logic         kl128, kl256, en128, en256, busy128, busy256;
  logic [15:0]  bc128, bc256;
  logic [4:0]   c128, c256;
  int           vec_cnt = 0;
  int           err_cnt = 0;

  aes_dec_feeder_if #(.W(32))  s128 ();
  aes_dec_feeder_if #(.W(128)) m128 ();
  aes_dec_feeder_if #(.W(32))  s256 ();
  aes_dec_feeder_if #(.W(128)) m256 ();

  aes_dec_feeder #(.NK(4), .NR(10), .CORE_LAT(11)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .key_in(key128), .key_load(kl128),
    .s(s128), .m(m128), .dec_key(dk128), .dec_state(ds128),
    .dec_enable(en128), .dec_result(res128), .busy(busy128), .blk_count(bc128));

  aes_dec_feeder #(.NK(8), .NR(14), .CORE_LAT(15)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .key_in(key256), .key_load(kl256),
    .s(s256), .m(m256), .dec_key(dk256), .dec_state(ds256),
    .dec_enable(en256), .dec_result(res256), .busy(busy256), .blk_count(bc256));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stand-in: plaintext appears only after exactly CORE_LAT enables with a known key/ciphertext pair.
  function automatic logic [127:0] plain128(input logic [127:0] k, input logic [127:0] ct);
    if (k == KA && ct == CA) return PA;
    if (k == KB && ct == CB) return PB;
    return GARB;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c128 <= '0;
      c256 <= '0;
    end else begin
      if (en128) c128 <= (c128 == 5'd11) ? 5'd1 : c128 + 5'd1;
      if (en256) c256 <= (c256 == 5'd15) ? 5'd1 : c256 + 5'd1;
    end
  end

  assign res128 = (c128 == 5'd11) ? plain128(dk128, ds128) : GARB;
  assign res256 = (c256 == 5'd15 && dk256 == K256 && ds256 == C256) ? PA : GARB;

  task automatic idle_inputs();
    s128.valid = 1'b0; s128.data = '0; s256.valid = 1'b0; s256.data = '0;
    kl128 = 1'b0; kl256 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one block following a valid pattern (MSB first); returns at the negedge after the last beat.
  task automatic send_blk(input bit big, input logic [127:0] ct, input logic [6:0] pat,
                          input int npat, input bit load, input logic [255:0] key);
    int idx;
    idx = 0;
    for (int i = 0; i < npat; i++) begin
      logic v;
      logic [31:0] w;
      @(negedge clk);
      v = pat[npat-1-i];
      w = v ? ct[127-32*idx -: 32] : 32'hbad0bad0;
      if (big) begin
        s256.valid = v; s256.data = w; kl256 = load && (i == 0); key256 = key;
      end else begin
        s128.valid = v; s128.data = w; kl128 = load && (i == 0); key128 = key[127:0];
      end
      @(posedge clk);
      if (v) idx++;
    end
    @(negedge clk);
    s128.valid = 1'b0; s256.valid = 1'b0; kl128 = 1'b0; kl256 = 1'b0;
  endtask

  // Counts enabled negedges until m_valid is seen; mv_k = -1 if the bound expires.
  task automatic run_out(input bit big, output int mv_k, output int en_cnt);
    mv_k = -1;
    en_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (big ? en256 : en128) en_cnt++;
      if (big ? m256.valid : m128.valid) begin
        mv_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vec_cnt++;
    if ({s128.ready, m128.valid, en128, busy128} !== 4'b0000) begin
      err_cnt++; $display("FAIL rst_ctrl got %b want 0000", {s128.ready, m128.valid, en128, busy128});
    end
    vec_cnt++;
    if (bc128 !== 16'd0 || dk128 !== 128'd0 || ds128 !== 128'd0 || m128.data !== 128'd0) begin
      err_cnt++; $display("FAIL rst_data got bc=%h key=%h st=%h md=%h want all 0", bc128, dk128, ds128, m128.data);
    end
    vec_cnt++;
    if ({s256.ready, m256.valid, en256, busy256} !== 4'b0000) begin
      err_cnt++; $display("FAIL rst_ctrl256 got %b want 0000", {s256.ready, m256.valid, en256, busy256});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({s128.ready, busy128} !== 2'b10) begin
      err_cnt++; $display("FAIL rst_release got s_ready,busy=%b want 10", {s128.ready, busy128});
    end
  endtask

  task automatic test_fips128();
    int k, e;
    do_reset();
    m128.ready = 1'b1;
    send_blk(1'b0, CA, 7'b0001111, 4, 1'b1, {128'd0, KA});
    run_out(1'b0, k, e);
    vec_cnt++;
    if (k !== 12) begin err_cnt++; $display("FAIL fips_latency got %0d want 12", k); end
    vec_cnt++;
    if (e !== 11) begin err_cnt++; $display("FAIL fips_enable_cycles got %0d want 11", e); end
    vec_cnt++;
    if (m128.data !== PA) begin err_cnt++; $display("FAIL fips_plain got %h want %h", m128.data, PA); end
    vec_cnt++;
    if (bc128 !== 16'd1 || dk128 !== KA) begin
      err_cnt++; $display("FAIL fips_count_key got bc=%0d key=%h want 1 %h", bc128, dk128, KA);
    end
    @(negedge clk);
    vec_cnt++;
    if ({s128.ready, m128.valid, busy128} !== 3'b100) begin
      err_cnt++; $display("FAIL fips_return got %b want 100", {s128.ready, m128.valid, busy128});
    end
  endtask

  task automatic test_backpressure();
    int k, e;
    do_reset();
    m128.ready = 1'b0;
    send_blk(1'b0, CA, 7'b0001111, 4, 1'b1, {128'd0, KA});
    run_out(1'b0, k, e);
    vec_cnt++;
    if (k !== 12) begin err_cnt++; $display("FAIL bp_latency got %0d want 12", k); end
    for (int i = 0; i < 20; i++) begin
      vec_cnt++;
      if ({m128.valid, s128.ready} !== 2'b10 || m128.data !== PA || bc128 !== 16'd1) begin
        err_cnt++;
        $display("FAIL bp_hold cyc %0d got v,rdy=%b data=%h bc=%0d want 10 %h 1",
                 i, {m128.valid, s128.ready}, m128.data, bc128, PA);
      end
      @(negedge clk);
    end
    m128.ready = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({s128.ready, m128.valid} !== 2'b10) begin
      err_cnt++; $display("FAIL bp_release got s_ready,m_valid=%b want 10", {s128.ready, m128.valid});
    end
  endtask

  task automatic test_gapped();
    int k, e;
    do_reset();
    m128.ready = 1'b1;
    send_blk(1'b0, CA, 7'b1001101, 7, 1'b1, {128'd0, KA});
    vec_cnt++;
    if (ds128 !== CA) begin err_cnt++; $display("FAIL gap_assembly got %h want %h", ds128, CA); end
    run_out(1'b0, k, e);
    vec_cnt++;
    if (m128.data !== PA || k !== 12 || bc128 !== 16'd1) begin
      err_cnt++; $display("FAIL gap_plain got %h lat=%0d bc=%0d want %h 12 1", m128.data, k, bc128, PA);
    end
    @(negedge clk);
    vec_cnt++;
    if (busy128 !== 1'b0) begin err_cnt++; $display("FAIL gap_idle got busy=%b want 0", busy128); end
  endtask

  task automatic test_key_guard();
    int k, e;
    do_reset();
    m128.ready = 1'b1;
    send_blk(1'b0, CA, 7'b0001111, 4, 1'b1, {128'd0, KA});
    key128 = KB;
    kl128  = 1'b1;
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (dk128 !== KA) begin err_cnt++; $display("FAIL kg_hold got %h want %h", dk128, KA); end
    kl128 = 1'b0;
    run_out(1'b0, k, e);
    vec_cnt++;
    if (m128.data !== PA || k < 0) begin err_cnt++; $display("FAIL kg_plain_a got %h want %h", m128.data, PA); end
    send_blk(1'b0, CB, 7'b0001111, 4, 1'b1, {128'd0, KB});
    vec_cnt++;
    if (dk128 !== KB) begin err_cnt++; $display("FAIL kg_new_key got %h want %h", dk128, KB); end
    run_out(1'b0, k, e);
    vec_cnt++;
    if (m128.data !== PB || k !== 12 || bc128 !== 16'd2) begin
      err_cnt++; $display("FAIL kg_plain_b got %h lat=%0d bc=%0d want %h 12 2", m128.data, k, bc128, PB);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int k, e, n;
    do_reset();
    m128.ready = 1'b1;
    send_blk(1'b0, CA, 7'b0001111, 4, 1'b1, {128'd0, KA});
    run_out(1'b0, k, e);
    @(negedge clk);
    send_blk(1'b0, CA, 7'b0001111, 4, 1'b0, {128'd0, KA});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (en128) n++;
      if (n == 5) break;
      @(negedge clk);
    end
    vec_cnt++;
    if (n !== 5 || bc128 !== 16'd1) begin
      err_cnt++; $display("FAIL mid_reach got enables=%0d bc=%0d want 5 1", n, bc128);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({en128, busy128, m128.valid} !== 3'b000 || bc128 !== 16'd0) begin
      err_cnt++; $display("FAIL mid_async got en,busy,mv=%b bc=%0d want 000 0", {en128, busy128, m128.valid}, bc128);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_blk(1'b0, CA, 7'b0001111, 4, 1'b1, {128'd0, KA});
    run_out(1'b0, k, e);
    vec_cnt++;
    if (m128.data !== PA || k !== 12 || e !== 11 || bc128 !== 16'd1) begin
      err_cnt++; $display("FAIL mid_recover got %h lat=%0d en=%0d bc=%0d want %h 12 11 1", m128.data, k, e, bc128, PA);
    end
    @(negedge clk);
  endtask

  task automatic test_aes256();
    int k, e;
    do_reset();
    m256.ready = 1'b1;
    send_blk(1'b1, C256, 7'b0001111, 4, 1'b1, K256);
    run_out(1'b1, k, e);
    vec_cnt++;
    if (k !== 16) begin err_cnt++; $display("FAIL a256_latency got %0d want 16", k); end
    vec_cnt++;
    if (e !== 15) begin err_cnt++; $display("FAIL a256_enable_cycles got %0d want 15", e); end
    vec_cnt++;
    if (m256.data !== PA || bc256 !== 16'd1 || dk256 !== K256) begin
      err_cnt++; $display("FAIL a256_plain got %h bc=%0d want %h 1", m256.data, bc256, PA);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    key128 = '0; key256 = '0;
    m128.ready = 1'b0; m256.ready = 1'b0;
    idle_inputs();
    test_reset();
    test_fips128();
    test_backpressure();
    test_gapped();
    test_key_guard();
    test_reset_mid_run();
    test_aes256();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
